sv_uart_rx: RTL and testbench
=============================

Name: sv_uart_rx

Overview:
AXI-Stream UART receiver: the receive-side counterpart of the team's UART transmitter. Same frame format: 1 start bit (0), DATA_WIDTH data bits LSB-first, STOP_BITS stop bits (1). Same 16-bit clocks-per-bit divider. Samples the asynchronous rxd line through a 2-FF synchronizer, mid-bit samples each bit, and presents received words on an AXI-Stream master with a one-word holding register. Framing and overrun errors are flagged.

Parameters:
DATA_WIDTH, 8, data bits per frame (5..16)
STOP_BITS, 1, stop bits checked per frame (1..2)

Ports:
iclk  input  1  system clock
irst  input  1  reset; synchronous, active-high
irx  input  1  asynchronous serial input, idle high
idivider  input  16  clocks per bit; values <2 unsupported; sampled at start-bit detect and held for the frame
m_axis_tdata  output  DATA_WIDTH  received word
m_axis_tvalid  output  1  word available
m_axis_tready  input  1  downstream accept
oframe_err  output  1  one-cycle pulse: a stop bit sampled 0
ooverrun  output  1  one-cycle pulse: a new word was dropped because the holding register was full
obusy  output  1  high while not in ST_IDLE

Behaviour:
- Reset values: m_axis_tvalid=0, m_axis_tdata=0, oframe_err=0, ooverrun=0, obusy=0, FSM=ST_IDLE. Synchronizer FFs reset to 1.
- Synchronizer: rx_s = irx delayed 2 iclk. All logic uses rx_s.
- Baud counter: 16-bit, cleared on entering any bit state. Increments each clock in a non-idle state. Bit tick when the counter reaches div_l-1, then the counter wraps to 0. div_l is idivider latched at start detect.
- States:
  - ST_IDLE: on rx_s falling edge (prev 1, now 1→0), latch div_l, go to ST_START.
  - ST_START: at half-bit (counter == div_l>>1, counter then cleared) check rx_s. If 0, go to ST_DATA with bit count 0. If 1 (glitch), return to ST_IDLE with no output and no error.
  - ST_DATA: every full bit period from the mid-start point, shift rx_s into the MSB of the shift register (shift right, so LSB-first arrives aligned). After DATA_WIDTH samples, go to ST_STOP.
  - ST_STOP: sample STOP_BITS bits at full-bit intervals. Any stop sample 0 sets an error flag for the frame. After the last stop sample, go to ST_IDLE immediately; there is no wait for the rest of the stop bit, which allows back-to-back frames.
- Output on the last stop sample:
  - If the frame has an error: pulse oframe_err for 1 cycle, discard the data, m_axis unchanged.
  - Else, if m_axis_tvalid=0, or m_axis_tready=1 in that same cycle: load m_axis_tdata and set tvalid on the next edge.
  - Else: pulse ooverrun; the old word is kept and the new word is dropped.
- AXIS: tvalid stays high with tdata stable until tready. tvalid clears on the cycle after the handshake unless a new word loads in the same cycle; in that case tvalid stays 1 with the new data.
- Latency: tvalid rises 1 iclk after the middle of the last stop bit.
- A falling edge while not in ST_IDLE is ignored.
- Reset mid-frame: aborts the frame immediately and drops any pending word (tvalid=0). After reset, the first accepted frame starts on a new falling edge.
- The counter is 16 bits with no overflow; div_l up to 65535 is supported.

Test Plan:
- idivider=16, send 0xA5 with 8N1 via a model TX, tready=1 → one beat with tdata=0xA5, no error pulses. tvalid rises about 16*9.5+3 clocks after the start edge.
- Back-to-back 0x00,0xFF,0x3C with 1 stop bit, idivider=10 → three beats in order, no errors.
- Stop bit forced 0 while sending 0x55 → oframe_err 1-cycle pulse, no tvalid.
- tready=0, send 0x11 then 0x22 → tdata stays 0x11, ooverrun pulses once. Raising tready then delivers 0x11 only.
- 3-clock low glitch on irx with idivider=16 → FSM returns to idle, no output and no error. A following frame 0x7E is received correctly.
- Assert irst mid-frame (during data bit 3), release, then send 0xC3 → only 0xC3 is delivered. STOP_BITS=2 variant with the second stop bit 0 → oframe_err.

Source files
------------

// File: rtl/sv_uart_rx.sv
// UART receiver: 2-FF synchronized input, mid-bit sampling, AXI-Stream output with a
// one-word holding register, framing and overrun error pulses.
module sv_uart_rx #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned STOP_BITS  = 1
) (
    input  logic                  iclk,
    input  logic                  irst,
    input  logic                  irx,
    input  logic [15:0]           idivider,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  oframe_err,
    output logic                  ooverrun,
    output logic                  obusy
);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_t;

    localparam logic [4:0] LastData = 5'(DATA_WIDTH - 1);
    localparam logic [4:0] LastStop = 5'(STOP_BITS - 1);

    state_t                state_q, state_d;
    logic                  rx_meta_q, rx_s_q, rx_prev_q;
    logic [15:0]           cnt_q, cnt_d, div_q, div_d;
    logic [4:0]            bit_q, bit_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d, tdata_q, tdata_d;
    logic                  err_q, err_d, tvalid_q, tvalid_d;
    logic                  ferr_q, ferr_d, ovr_q, ovr_d;
    logic                  mid_tick, bit_tick, frame_bad;

    assign mid_tick = (cnt_q == (div_q >> 1));
    assign bit_tick = (cnt_q == (div_q - 16'd1));

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        div_d     = div_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        err_d     = err_q;
        tdata_d   = tdata_q;
        tvalid_d  = tvalid_q;
        ferr_d    = 1'b0;
        ovr_d     = 1'b0;
        frame_bad = err_q | ~rx_s_q;

        if (tvalid_q && m_axis_tready) begin
            tvalid_d = 1'b0;
        end

        unique case (state_q)
            StIdle: begin
                if (rx_prev_q && !rx_s_q) begin
                    div_d   = idivider;
                    cnt_d   = 16'd0;
                    state_d = StStart;
                end
            end
            StStart: begin
                if (mid_tick) begin
                    cnt_d = 16'd0;
                    if (!rx_s_q) begin
                        state_d = StData;
                        bit_d   = 5'd0;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            StData: begin
                if (bit_tick) begin
                    cnt_d   = 16'd0;
                    shift_d = {rx_s_q, shift_q[DATA_WIDTH-1:1]};
                    if (bit_q == LastData) begin
                        state_d = StStop;
                        bit_d   = 5'd0;
                        err_d   = 1'b0;
                    end else begin
                        bit_d = bit_q + 5'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            StStop: begin
                if (bit_tick) begin
                    cnt_d = 16'd0;
                    if (bit_q == LastStop) begin
                        // Return to idle mid-stop so a back-to-back start edge is caught.
                        state_d = StIdle;
                        if (frame_bad) begin
                            ferr_d = 1'b1;
                        end else if (!tvalid_q || m_axis_tready) begin
                            tdata_d  = shift_q;
                            tvalid_d = 1'b1;
                        end else begin
                            ovr_d = 1'b1;
                        end
                    end else begin
                        err_d = frame_bad;
                        bit_d = bit_q + 5'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge iclk) begin
        if (irst) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            rx_prev_q <= 1'b1;
            state_q   <= StIdle;
            cnt_q     <= 16'd0;
            div_q     <= 16'd0;
            bit_q     <= 5'd0;
            shift_q   <= '0;
            err_q     <= 1'b0;
            tdata_q   <= '0;
            tvalid_q  <= 1'b0;
            ferr_q    <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            rx_meta_q <= irx;
            rx_s_q    <= rx_meta_q;
            rx_prev_q <= rx_s_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            div_q     <= div_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            err_q     <= err_d;
            tdata_q   <= tdata_d;
            tvalid_q  <= tvalid_d;
            ferr_q    <= ferr_d;
            ovr_q     <= ovr_d;
        end
    end

    assign m_axis_tdata  = tdata_q;
    assign m_axis_tvalid = tvalid_q;
    assign oframe_err    = ferr_q;
    assign ooverrun      = ovr_q;
    assign obusy         = (state_q != StIdle);

endmodule

// File: tb/tb_sv_uart_rx.sv
// Self-checking bench for sv_uart_rx: a model transmitter drives frames, expected words go
// into a scoreboard queue and are compared against words handed off on the AXI-Stream port.
module tb_sv_uart_rx;

    logic        iclk = 1'b0;
    logic        irst = 1'b1;
    logic        irx = 1'b1;
    logic        irx2 = 1'b1;
    logic [15:0] idivider = 16'd16;
    logic        tready = 1'b1;
    logic [7:0]  tdata, tdata2;
    logic        tvalid, tvalid2, ferr, ferr2, ovr, ovr2, busy, busy2;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int rise_cyc = 0;
    int ferr_cnt = 0;
    int ovr_cnt = 0;
    int ferr2_cnt = 0;
    logic tvalid_prev = 1'b0;
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    logic [7:0] got2_q[$];

    sv_uart_rx #(.DATA_WIDTH(8), .STOP_BITS(1)) u_dut (
        .iclk(iclk), .irst(irst), .irx(irx), .idivider(idivider),
        .m_axis_tdata(tdata), .m_axis_tvalid(tvalid), .m_axis_tready(tready),
        .oframe_err(ferr), .ooverrun(ovr), .obusy(busy)
    );

    sv_uart_rx #(.DATA_WIDTH(8), .STOP_BITS(2)) u_dut2 (
        .iclk(iclk), .irst(irst), .irx(irx2), .idivider(idivider),
        .m_axis_tdata(tdata2), .m_axis_tvalid(tvalid2), .m_axis_tready(1'b1),
        .oframe_err(ferr2), .ooverrun(ovr2), .obusy(busy2)
    );

    always #5 iclk = ~iclk;

    always @(posedge iclk) cyc <= cyc + 1;

    // Monitor: collects handshaked words and counts error-pulse cycles.
    always @(negedge iclk) begin
        if (tvalid && tready) got_q.push_back(tdata);
        if (tvalid2) got2_q.push_back(tdata2);
        if (ferr) ferr_cnt <= ferr_cnt + 1;
        if (ovr) ovr_cnt <= ovr_cnt + 1;
        if (ferr2) ferr2_cnt <= ferr2_cnt + 1;
        if (tvalid && !tvalid_prev) rise_cyc <= cyc;
        tvalid_prev <= tvalid;
    end

    // Model transmitter: start bit, 8 data bits LSB-first, nstop stop bits from 'stops'.
    task automatic send_frame(input logic [7:0] data, input int div, input logic [1:0] stops,
                              input int nstop, input bit line2);
        logic [10:0] bits;
        bits = {stops, data, 1'b0};
        for (int i = 0; i < 9 + nstop; i++) begin
            if (line2) irx2 = bits[i];
            else irx = bits[i];
            repeat (div) @(negedge iclk);
        end
        irx  = 1'b1;
        irx2 = 1'b1;
    endtask

    task automatic test_reset;
        irst = 1'b1;
        repeat (4) @(negedge iclk);
        checks++; if (tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid got %b want 0", tvalid); end
        checks++; if (tdata !== 8'h00) begin errors++; $display("FAIL reset_tdata got %h want 00", tdata); end
        checks++; if (ferr !== 1'b0) begin errors++; $display("FAIL reset_ferr got %b want 0", ferr); end
        checks++; if (ovr !== 1'b0) begin errors++; $display("FAIL reset_ovr got %b want 0", ovr); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        irst = 1'b0;
        repeat (4) @(negedge iclk);
    endtask

    task automatic test_single;
        int f0, o0, start, lat;
        logic [7:0] e;
        f0 = ferr_cnt; o0 = ovr_cnt;
        idivider = 16'd16;
        start = cyc;
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 16, 2'b11, 1, 1'b0);
        repeat (40) @(negedge iclk);
        lat = rise_cyc - start;
        checks++; if (got_q.size() != 1) begin errors++; $display("FAIL single_count got %0d want 1", got_q.size()); end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++; if (got_q[0] !== e) begin errors++; $display("FAIL single_data got %h want %h", got_q[0], e); end
            void'(got_q.pop_front());
        end
        checks++; if (lat < 150 || lat > 160) begin errors++; $display("FAIL single_latency got %0d want 150..160", lat); end
        checks++; if (ferr_cnt != f0 || ovr_cnt != o0) begin errors++; $display("FAIL single_errs got ferr+%0d ovr+%0d want 0", ferr_cnt - f0, ovr_cnt - o0); end
        exp_q.delete(); got_q.delete();
    endtask

    task automatic test_back_to_back;
        int f0;
        logic [7:0] words[3];
        logic [7:0] e;
        words = '{8'h00, 8'hFF, 8'h3C};
        f0 = ferr_cnt;
        idivider = 16'd10;
        foreach (words[i]) begin
            exp_q.push_back(words[i]);
            send_frame(words[i], 10, 2'b11, 1, 1'b0);
        end
        repeat (30) @(negedge iclk);
        checks++; if (got_q.size() != 3) begin errors++; $display("FAIL b2b_count got %0d want 3", got_q.size()); end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++; if (got_q[0] !== e) begin errors++; $display("FAIL b2b_data got %h want %h", got_q[0], e); end
            void'(got_q.pop_front());
        end
        checks++; if (ferr_cnt != f0) begin errors++; $display("FAIL b2b_ferr got +%0d want 0", ferr_cnt - f0); end
        exp_q.delete(); got_q.delete();
    endtask

    task automatic test_frame_err;
        int f0;
        f0 = ferr_cnt;
        idivider = 16'd16;
        send_frame(8'h55, 16, 2'b00, 1, 1'b0);
        repeat (40) @(negedge iclk);
        checks++; if (ferr_cnt - f0 != 1) begin errors++; $display("FAIL ferr_pulse got %0d cycles want 1", ferr_cnt - f0); end
        checks++; if (got_q.size() != 0) begin errors++; $display("FAIL ferr_nodata got %0d words want 0", got_q.size()); end
        got_q.delete();
    endtask

    task automatic test_overrun;
        int o0;
        logic [7:0] e;
        o0 = ovr_cnt;
        idivider = 16'd16;
        tready = 1'b0;
        send_frame(8'h11, 16, 2'b11, 1, 1'b0);
        send_frame(8'h22, 16, 2'b11, 1, 1'b0);
        repeat (40) @(negedge iclk);
        checks++; if (tvalid !== 1'b1) begin errors++; $display("FAIL ovr_tvalid got %b want 1", tvalid); end
        checks++; if (tdata !== 8'h11) begin errors++; $display("FAIL ovr_tdata got %h want 11", tdata); end
        checks++; if (ovr_cnt - o0 != 1) begin errors++; $display("FAIL ovr_pulse got %0d cycles want 1", ovr_cnt - o0); end
        exp_q.push_back(8'h11);
        tready = 1'b1;
        repeat (5) @(negedge iclk);
        checks++; if (got_q.size() != 1) begin errors++; $display("FAIL ovr_count got %0d want 1", got_q.size()); end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++; if (got_q[0] !== e) begin errors++; $display("FAIL ovr_data got %h want %h", got_q[0], e); end
            void'(got_q.pop_front());
        end
        checks++; if (tvalid !== 1'b0) begin errors++; $display("FAIL ovr_drain got %b want 0", tvalid); end
        exp_q.delete(); got_q.delete();
    endtask

    task automatic test_glitch;
        int f0;
        logic [7:0] e;
        f0 = ferr_cnt;
        idivider = 16'd16;
        irx = 1'b0;
        repeat (3) @(negedge iclk);
        irx = 1'b1;
        repeat (40) @(negedge iclk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL glitch_busy got %b want 0", busy); end
        checks++; if (got_q.size() != 0 || ferr_cnt != f0) begin errors++; $display("FAIL glitch_quiet got %0d words ferr+%0d want 0", got_q.size(), ferr_cnt - f0); end
        exp_q.push_back(8'h7E);
        send_frame(8'h7E, 16, 2'b11, 1, 1'b0);
        repeat (40) @(negedge iclk);
        checks++; if (got_q.size() != 1) begin errors++; $display("FAIL glitch_count got %0d want 1", got_q.size()); end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++; if (got_q[0] !== e) begin errors++; $display("FAIL glitch_data got %h want %h", got_q[0], e); end
            void'(got_q.pop_front());
        end
        exp_q.delete(); got_q.delete();
    endtask

    task automatic test_reset_mid;
        logic [7:0] e;
        idivider = 16'd16;
        tready = 1'b0;
        send_frame(8'h99, 16, 2'b11, 1, 1'b0);
        repeat (20) @(negedge iclk);
        // Partial frame: start bit, data bits 0..2, reset half-way through bit 3.
        irx = 1'b0; repeat (16) @(negedge iclk);
        irx = 1'b1; repeat (48) @(negedge iclk);
        irx = 1'b0; repeat (8) @(negedge iclk);
        irst = 1'b1; repeat (2) @(negedge iclk);
        irx = 1'b1;
        irst = 1'b0;
        repeat (200) @(negedge iclk);
        checks++; if (tvalid !== 1'b0) begin errors++; $display("FAIL rstmid_tvalid got %b want 0", tvalid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b want 0", busy); end
        tready = 1'b1;
        repeat (2) @(negedge iclk);
        exp_q.push_back(8'hC3);
        send_frame(8'hC3, 16, 2'b11, 1, 1'b0);
        repeat (40) @(negedge iclk);
        checks++; if (got_q.size() != 1) begin errors++; $display("FAIL rstmid_count got %0d want 1", got_q.size()); end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++; if (got_q[0] !== e) begin errors++; $display("FAIL rstmid_data got %h want %h", got_q[0], e); end
            void'(got_q.pop_front());
        end
        exp_q.delete(); got_q.delete();
    endtask

    task automatic test_stop2;
        int f0;
        f0 = ferr2_cnt;
        idivider = 16'd12;
        got2_q.delete();
        send_frame(8'h5A, 12, 2'b01, 2, 1'b1);
        repeat (40) @(negedge iclk);
        checks++; if (ferr2_cnt - f0 != 1) begin errors++; $display("FAIL stop2_ferr got %0d cycles want 1", ferr2_cnt - f0); end
        checks++; if (got2_q.size() != 0) begin errors++; $display("FAIL stop2_nodata got %0d words want 0", got2_q.size()); end
        send_frame(8'hB4, 12, 2'b11, 2, 1'b1);
        repeat (40) @(negedge iclk);
        checks++; if (got2_q.size() != 1 || got2_q[0] !== 8'hB4) begin errors++; $display("FAIL stop2_good got %0d words first %h want 1 word b4", got2_q.size(), (got2_q.size() > 0) ? got2_q[0] : 8'hxx); end
        checks++; if (ferr2_cnt - f0 != 1) begin errors++; $display("FAIL stop2_goodferr got %0d cycles want 1", ferr2_cnt - f0); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_frame_err();
        test_overrun();
        test_glitch();
        test_reset_mid();
        test_stop2();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
